reg_wb_ctrl: RTL and testbench

- Writer-side controller for the 32x32 integer register file. It produces the file's single write port (rd_waddr / rd_wdata / wen).
- Merges two result sources: single-cycle EX results, and long-latency LSU/divider results that arrive on a valid/ready handshake and are buffered in a small FIFO.
- Keeps a busy scoreboard of registers with outstanding long-latency writes, so ID can stall on RAW hazards.

---
 rtl/rv_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 50 +++++
 rtl/reg_wb_ctrl.sv | 151 +++++++++++++++
 tb/tb_reg_wb_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared integer register-file types and constants for the writeback path.
package rv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int REG_NUM    = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } wb_entry_t;

  // Which source the writeback output register loads in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_EX,
    SRC_FIFO
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-port controller: arbitrates EX results against buffered
// long-latency results and tracks registers with outstanding long writes.
module reg_wb_ctrl
  import rv_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ex_wen,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [XLEN-1:0]       ex_wdata,
  output logic                  ex_stall,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_waddr,
  input  logic [XLEN-1:0]       lsu_wdata,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_raddr,
  input  logic [REG_ADDR_W-1:0] rs2_raddr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [REG_ADDR_W-1:0] rd_waddr,
  output logic [XLEN-1:0]       rd_wdata,
  output logic                  wen
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  wb_entry_t             fifo_head;
  wb_entry_t             lsu_entry;
  wb_src_e               src;
  logic                  ex_req;
  logic                  starved;
  logic                  stall_q;
  logic [CW-1:0]         starve_cnt;
  logic [REG_NUM-1:0]    busy_q;
  logic [REG_NUM-1:0]    busy_next;
  logic                  wen_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [XLEN-1:0]       wdata_q;

  // Ready depends only on registered FIFO state, never on lsu_valid.
  assign lsu_ready = !fifo_full;
  assign lsu_entry = '{waddr: lsu_waddr, wdata: lsu_wdata};
  assign fifo_push = lsu_valid && !fifo_full && (lsu_waddr != REG_ZERO);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (lsu_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign ex_req = ex_wen && (ex_waddr != REG_ZERO) && !stall_q;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    src      = SRC_NONE;
    fifo_pop = 1'b0;
    if (stall_q) begin
      fifo_pop = !fifo_empty;
      src      = fifo_empty ? SRC_NONE : SRC_FIFO;
    end else if (ex_req) begin
      src = SRC_EX;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      src      = SRC_FIFO;
    end
  end

  assign starved = !fifo_empty && !fifo_pop;

  // A full run of starved cycles forces a one-cycle EX stall to drain the head.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      if (!starved) begin
        starve_cnt <= '0;
      end else if (starve_cnt == CW'(STARVE_MAX - 1)) begin
        starve_cnt <= '0;
        stall_q    <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign ex_stall = stall_q;

  // Clear-then-set ordering makes a same-cycle reissue win over the pop.
  always_comb begin
    busy_next = busy_q;
    if (fifo_pop) busy_next[fifo_head.waddr] = 1'b0;
    if (issue_valid && (issue_rd != REG_ZERO)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_next;
  end

  assign rs1_busy = busy_q[rs1_raddr];
  assign rs2_busy = busy_q[rs2_raddr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      unique case (src)
        SRC_EX: begin
          wen_q   <= 1'b1;
          waddr_q <= ex_waddr;
          wdata_q <= ex_wdata;
        end
        SRC_FIFO: begin
          wen_q   <= 1'b1;
          waddr_q <= fifo_head.waddr;
          wdata_q <= fifo_head.wdata;
        end
        default: begin
          wen_q   <= 1'b0;
          waddr_q <= '0;
          wdata_q <= '0;
        end
      endcase
    end
  end

  assign wen      = wen_q;
  assign rd_waddr = waddr_q;
  assign rd_wdata = wdata_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Scoreboard bench for reg_wb_ctrl: directed stimulus queues expected writes,
// a negedge monitor pops and compares every write-port cycle.
module tb_reg_wb_ctrl;
  import rv_pkg::*;

  logic                  clk;
  logic                  rstn;
  logic                  ex_wen;
  logic [REG_ADDR_W-1:0] ex_waddr;
  logic [XLEN-1:0]       ex_wdata;
  logic                  ex_stall;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_waddr;
  logic [XLEN-1:0]       lsu_wdata;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [REG_ADDR_W-1:0] rs1_raddr;
  logic [REG_ADDR_W-1:0] rs2_raddr;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic [REG_ADDR_W-1:0] rd_waddr;
  logic [XLEN-1:0]       rd_wdata;
  logic                  wen;

  wb_entry_t exp_q[$];
  int        n_cmp = 0;
  int        n_err = 0;
  bit        mon_en = 1'b0;
  bit        pending [REG_NUM];

  reg_wb_ctrl #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .ex_wen      (ex_wen),
    .ex_waddr    (ex_waddr),
    .ex_wdata    (ex_wdata),
    .ex_stall    (ex_stall),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_waddr   (lsu_waddr),
    .lsu_wdata   (lsu_wdata),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_raddr   (rs1_raddr),
    .rs2_raddr   (rs2_raddr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd_waddr    (rd_waddr),
    .rd_wdata    (rd_wdata),
    .wen         (wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_wen      = 1'b0;
    ex_waddr    = '0;
    ex_wdata    = '0;
    lsu_valid   = 1'b0;
    lsu_waddr   = '0;
    lsu_wdata   = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic expect_wb(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{waddr: a, wdata: d});
  endtask

  // Monitor: every cycle either matches the next queued write or is idle-zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wen) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write",
                   rd_waddr, rd_wdata);
        end else begin
          wb_entry_t e;
          e = exp_q.pop_front();
          check("wb_addr", 64'(rd_waddr), 64'(e.waddr));
          check("wb_data", 64'(rd_wdata), 64'(e.wdata));
        end
      end else begin
        check("idle_zero", {27'b0, rd_waddr, rd_wdata}, 64'd0);
      end
    end
  end

  // ID must never issue to a register whose long-latency result is outstanding.
  always @(posedge clk) begin
    if (rstn && issue_valid && issue_rd != 0)
      assert (!pending[issue_rd]) else $error("WAW issue to outstanding rd %0d", issue_rd);
  end

  initial begin
    bit xfer;
    bit acc;
    int ex_idx;
    int lsu_idx;

    idle_inputs();
    rs1_raddr = '0;
    rs2_raddr = '0;
    rstn = 1'b0;
    tick();
    tick();
    rstn   = 1'b1;
    mon_en = 1'b1;

    // Reset from a state with wen high.
    expect_wb(5'd1, 32'hA5A5_A5A5);
    ex_wen = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'hA5A5_A5A5;
    tick();
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    check("rst_wen", 64'(wen), 64'd0);
    check("rst_rd_waddr", 64'(rd_waddr), 64'd0);
    check("rst_rd_wdata", 64'(rd_wdata), 64'd0);
    check("rst_ex_stall", 64'(ex_stall), 64'd0);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    rstn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1_raddr = 5'(i);
      rs2_raddr = 5'(31 - i);
      tick();
      check($sformatf("rst_rs1_busy_%0d", i), 64'(rs1_busy), 64'd0);
      check($sformatf("rst_rs2_busy_%0d", 31 - i), 64'(rs2_busy), 64'd0);
    end

    // EX-only write, then an EX write to x0.
    expect_wb(5'd5, 32'hDEAD_BEEF);
    ex_wen = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hDEAD_BEEF;
    tick();
    check("ex_wen", 64'(wen), 64'd1);
    ex_waddr = 5'd0; ex_wdata = 32'h1111_1111;
    tick();
    check("ex_x0_no_write", 64'(wen), 64'd0);
    idle_inputs();
    tick();

    // Issue rd=7, deliver its result with EX idle.
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle_inputs();
    pending[7] = 1'b1;
    rs1_raddr = 5'd7; rs2_raddr = 5'd8;
    #1;
    check("busy_rd7", 64'(rs1_busy), 64'd1);
    check("busy_rd8", 64'(rs2_busy), 64'd0);
    lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'h0000_1234;
    #1;
    check("lsu_ready_empty", 64'(lsu_ready), 64'd1);
    expect_wb(5'd7, 32'h0000_1234);
    tick();
    pending[7] = 1'b0;
    idle_inputs();
    check("busy_rd7_pop_cycle", 64'(rs1_busy), 64'd1);
    tick();
    check("busy_rd7_cleared", 64'(rs1_busy), 64'd0);
    check("lsu_write_wen", 64'(wen), 64'd1);
    tick();

    // EX every cycle vs three LSU results: backpressure and a starvation stall.
    for (int i = 0; i < 5; i++) expect_wb(5'(10 + i), 32'h1000 + i);
    expect_wb(5'd20, 32'h2000);
    expect_wb(5'd15, 32'h1005);
    expect_wb(5'd21, 32'h2001);
    expect_wb(5'd22, 32'h2002);
    ex_idx  = 0;
    lsu_idx = 0;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("ex_stall_c%0d", c), 64'(ex_stall), 64'(c == 5));
      if (ex_idx < 6) begin
        ex_wen = 1'b1; ex_waddr = 5'(10 + ex_idx); ex_wdata = 32'h1000 + 32'(ex_idx);
      end else begin
        ex_wen = 1'b0; ex_waddr = '0; ex_wdata = '0;
      end
      if (lsu_idx < 3) begin
        lsu_valid = 1'b1; lsu_waddr = 5'(20 + lsu_idx); lsu_wdata = 32'h2000 + 32'(lsu_idx);
      end else begin
        lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
      end
      #1;
      if (c == 2) check("lsu_ready_full", 64'(lsu_ready), 64'd0);
      xfer = lsu_valid && lsu_ready;
      acc  = ex_wen && !ex_stall;
      tick();
      if (xfer) lsu_idx++;
      if (acc)  ex_idx++;
    end
    idle_inputs();

    // Pop of rd=9 coinciding with a reissue of rd=9: busy stays set.
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    idle_inputs();
    pending[9] = 1'b1;
    expect_wb(5'd9, 32'h0000_9999);
    lsu_valid = 1'b1; lsu_waddr = 5'd9; lsu_wdata = 32'h0000_9999;
    tick();
    pending[9] = 1'b0;
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    idle_inputs();
    pending[9] = 1'b1;
    rs1_raddr = 5'd9;
    #1;
    check("busy_set_wins", 64'(rs1_busy), 64'd1);
    expect_wb(5'd9, 32'h0000_5A5A);
    lsu_valid = 1'b1; lsu_waddr = 5'd9; lsu_wdata = 32'h0000_5A5A;
    tick();
    pending[9] = 1'b0;
    idle_inputs();
    tick();
    check("busy_rd9_cleared", 64'(rs1_busy), 64'd0);
    tick();

    // LSU transfer to x0 handshakes but is never enqueued.
    expect_wb(5'd12, 32'h3000);
    expect_wb(5'd13, 32'h3001);
    expect_wb(5'd14, 32'h3002);
    expect_wb(5'd11, 32'h0000_000B);
    ex_wen = 1'b1; ex_waddr = 5'd12; ex_wdata = 32'h3000;
    lsu_valid = 1'b1; lsu_waddr = 5'd11; lsu_wdata = 32'h0000_000B;
    tick();
    ex_waddr = 5'd13; ex_wdata = 32'h3001;
    lsu_waddr = 5'd0; lsu_wdata = 32'h0000_0BAD;
    #1;
    check("x0_ready", 64'(lsu_ready), 64'd1);
    tick();
    ex_waddr = 5'd14; ex_wdata = 32'h3002;
    lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
    #1;
    check("x0_not_enqueued", 64'(lsu_ready), 64'd1);
    tick();
    idle_inputs();
    tick();
    tick();
    tick();

    // Reset while the FIFO is full and rd=3 is busy.
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    idle_inputs();
    pending[3] = 1'b1;
    expect_wb(5'd15, 32'h4000);
    expect_wb(5'd16, 32'h4001);
    ex_wen = 1'b1; ex_waddr = 5'd15; ex_wdata = 32'h4000;
    lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h0000_0033;
    tick();
    pending[3] = 1'b0;
    ex_waddr = 5'd16; ex_wdata = 32'h4001;
    lsu_waddr = 5'd4; lsu_wdata = 32'h0000_0044;
    tick();
    idle_inputs();
    rs1_raddr = 5'd3;
    #1;
    check("pre_reset_full", 64'(lsu_ready), 64'd0);
    check("pre_reset_busy3", 64'(rs1_busy), 64'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("post_reset_ready", 64'(lsu_ready), 64'd1);
    check("post_reset_busy3", 64'(rs1_busy), 64'd0);
    check("post_reset_stall", 64'(ex_stall), 64'd0);
    check("post_reset_wen", 64'(wen), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check("post_reset_still_empty", 64'(lsu_ready), 64'd1);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
